// File: rtl/cache_pkg.sv
// Shared types and field-width helpers for the N-way read cache.
package cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // Index width for n entries; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU for one set: victim selection and touch update.
// Node i has children 2i+1 / 2i+2; a 0 bit sends the victim search left.
module plru_tree #(
  parameter int WAYS = 2,
  localparam int LVL = $clog2(WAYS),
  localparam int WAY_W = (LVL > 0) ? LVL : 1,
  localparam int BITS_W = (WAYS > 1) ? WAYS - 1 : 1
) (
  input  logic [BITS_W-1:0] bits,
  input  logic [WAY_W-1:0]  touch_way,
  output logic [WAY_W-1:0]  victim,
  output logic [BITS_W-1:0] bits_next
);

  // Walk the tree following the LRU pointers, then walk it again pointing away from the touched way.
  always_comb begin
    int   node;
    logic d;
    victim    = '0;
    bits_next = bits;
    node      = 0;
    d         = 1'b0;
    for (int l = 0; l < LVL; l++) begin
      d = 1'b0;
      for (int n = 0; n < BITS_W; n++) begin
        d = d | (bits[n] & (n == node));
      end
      victim = WAY_W'({victim, d});
      node   = 2 * node + 1 + int'(d);
    end
    node = 0;
    for (int l = 0; l < LVL; l++) begin
      d = 1'(touch_way >> (LVL - 1 - l));
      for (int n = 0; n < BITS_W; n++) begin
        bits_next[n] = (n == node) ? ~d : bits_next[n];
      end
      node = 2 * node + 1 + int'(d);
    end
  end

endmodule

// File: rtl/cache_ctrl_nway.sv
// N-way set-associative write-through read cache with tree-PLRU replacement,
// flush and saturating hit/miss counters.
module cache_ctrl_nway
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 2,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rd_en,
  input  logic                         wr_en,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         ready,
  input  logic                         flush,
  output logic                         mem_rd_req,
  output logic                         mem_wr_req,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W*LINE_WORDS-1:0] mem_rdata,
  input  logic                         mem_ready,
  output logic [CNT_W-1:0]             hit_cnt,
  output logic [CNT_W-1:0]             miss_cnt
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int SET_BITS  = $clog2(SETS);
  localparam int TAG_LSB   = 2 + WORD_BITS + SET_BITS;
  localparam int TAG_W     = ADDR_W - TAG_LSB;
  localparam int WAY_W     = idx_w(WAYS);
  localparam int SET_W     = idx_w(SETS);
  localparam int WORD_W    = idx_w(LINE_WORDS);
  localparam int PLRU_W    = (WAYS > 1) ? WAYS - 1 : 1;

  state_t             state_r;
  logic [WAYS-1:0]    valid_r [SETS];
  logic [TAG_W-1:0]   tag_r   [SETS][WAYS];
  logic [DATA_W-1:0]  data_r  [SETS][WAYS][LINE_WORDS];
  logic [PLRU_W-1:0]  plru_r  [SETS];
  logic               flush_pend_r;
  logic               mem_rd_req_r;
  logic               mem_wr_req_r;
  logic [ADDR_W-1:0]  mem_addr_r;
  logic [DATA_W-1:0]  mem_wdata_r;
  logic [CNT_W-1:0]   hit_cnt_r;
  logic [CNT_W-1:0]   miss_cnt_r;

  logic [SET_W-1:0]   set_s;
  logic [WORD_W-1:0]  word_s;
  logic [TAG_W-1:0]   tag_s;
  logic               read_req_s;
  logic               hit_s;
  logic [WAY_W-1:0]   hit_way_s;
  logic               inv_found_s;
  logic [WAY_W-1:0]   inv_way_s;
  logic [WAY_W-1:0]   plru_victim_s;
  logic [WAY_W-1:0]   fill_way_s;
  logic [WAY_W-1:0]   touch_way_s;
  logic [PLRU_W-1:0]  plru_next_s;
  logic [DATA_W-1:0]  fill_line_s [LINE_WORDS];
  logic               ready_s;
  logic [DATA_W-1:0]  rdata_s;

  assign set_s       = SET_W'(addr >> (2 + WORD_BITS)) & SET_W'(SETS - 1);
  assign word_s      = WORD_W'(addr >> 2) & WORD_W'(LINE_WORDS - 1);
  assign tag_s       = TAG_W'(addr >> TAG_LSB);
  assign read_req_s  = rd_en & ~wr_en;
  assign fill_way_s  = inv_found_s ? inv_way_s : plru_victim_s;
  assign touch_way_s = (state_r == ST_FILL) ? fill_way_s : hit_way_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Tag compare across the addressed set, plus lowest-index invalid way for fills.
  always_comb begin
    logic match;
    hit_s       = 1'b0;
    hit_way_s   = '0;
    inv_found_s = 1'b0;
    inv_way_s   = '0;
    match       = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      match     = valid_r[set_s][w] && (tag_r[set_s][w] == tag_s);
      hit_s     = hit_s | match;
      hit_way_s = match ? WAY_W'(w) : hit_way_s;
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      inv_found_s = inv_found_s | ~valid_r[set_s][w];
      inv_way_s   = valid_r[set_s][w] ? inv_way_s : WAY_W'(w);
    end
  end

  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits      (plru_r[set_s]),
    .touch_way (touch_way_s),
    .victim    (plru_victim_s),
    .bits_next (plru_next_s)
  );

  // Hits answer in the request cycle; fills forward the SRAM line in the mem_ready cycle.
  always_comb begin
    for (int w = 0; w < LINE_WORDS; w++) begin
      fill_line_s[w] = mem_rdata[w*DATA_W +: DATA_W];
    end
    ready_s = 1'b1;
    rdata_s = '0;
    case (state_r)
      ST_IDLE: begin
        ready_s = ~(rd_en | wr_en) | (read_req_s & hit_s);
        rdata_s = (read_req_s && hit_s) ? data_r[set_s][hit_way_s][word_s] : '0;
      end
      ST_FILL: begin
        ready_s = mem_ready;
        rdata_s = mem_ready ? fill_line_s[word_s] : '0;
      end
      ST_WRITE: begin
        ready_s = mem_ready;
        rdata_s = '0;
      end
      default: begin
        ready_s = 1'b1;
        rdata_s = '0;
      end
    endcase
  end

  // Control FSM, valid/PLRU state and counters; reset drops any in-flight SRAM request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      flush_pend_r <= 1'b0;
      mem_rd_req_r <= 1'b0;
      mem_wr_req_r <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
      hit_cnt_r    <= '0;
      miss_cnt_r   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_r[s] <= '0;
        plru_r[s]  <= '0;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) valid_r[s] <= '0;
          end
          if (wr_en) begin
            state_r      <= ST_WRITE;
            mem_wr_req_r <= 1'b1;
            mem_addr_r   <= addr & ~ADDR_W'(3);
            mem_wdata_r  <= wdata;
          end else if (rd_en) begin
            if (hit_s) begin
              plru_r[set_s] <= plru_next_s;
              hit_cnt_r     <= sat_inc(hit_cnt_r);
            end else begin
              state_r      <= ST_FILL;
              mem_rd_req_r <= 1'b1;
              mem_addr_r   <= addr & ~ADDR_W'(LINE_WORDS * 4 - 1);
            end
          end
        end
        ST_FILL: begin
          if (mem_ready) begin
            state_r       <= ST_IDLE;
            mem_rd_req_r  <= 1'b0;
            flush_pend_r  <= 1'b0;
            miss_cnt_r    <= sat_inc(miss_cnt_r);
            plru_r[set_s] <= plru_next_s;
            // A flush seen during the fill wins over the valid bit the fill would set.
            if (flush || flush_pend_r) begin
              for (int s = 0; s < SETS; s++) valid_r[s] <= '0;
            end else begin
              valid_r[set_s][fill_way_s] <= 1'b1;
            end
          end else if (flush) begin
            flush_pend_r <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (mem_ready) begin
            state_r      <= ST_IDLE;
            mem_wr_req_r <= 1'b0;
            flush_pend_r <= 1'b0;
            if (flush || flush_pend_r) begin
              for (int s = 0; s < SETS; s++) valid_r[s] <= '0;
            end
          end else if (flush) begin
            flush_pend_r <= 1'b1;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          mem_rd_req_r <= 1'b0;
          mem_wr_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Tag and data storage: line install on fill, word update on a write hit.
  always_ff @(posedge clk) begin
    if (state_r == ST_FILL && mem_ready) begin
      tag_r[set_s][fill_way_s] <= tag_s;
      for (int w = 0; w < LINE_WORDS; w++) begin
        data_r[set_s][fill_way_s][w] <= fill_line_s[w];
      end
    end else if (state_r == ST_WRITE && mem_ready && hit_s) begin
      data_r[set_s][hit_way_s][word_s] <= wdata;
    end
  end

  assign ready      = ready_s;
  assign rdata      = rdata_s;
  assign mem_rd_req = mem_rd_req_r;
  assign mem_wr_req = mem_wr_req_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wdata  = mem_wdata_r;
  assign hit_cnt    = hit_cnt_r;
  assign miss_cnt   = miss_cnt_r;

endmodule

// File: tb/tb_cache_ctrl_nway.sv
// Directed + random bench for cache_ctrl_nway (2-way, 64 sets, 2-word lines, 4-bit counters)
// against an LRU-per-set line model and a word-addressed SRAM image.
module tb_cache_ctrl_nway;

  localparam int NW = 2;
  localparam int CMAX = 15;

  logic        clk, rst, rd_en, wr_en, flush, mem_ready;
  logic [31:0] addr, wdata, rdata, mem_addr, mem_wdata;
  logic [63:0] mem_rdata;
  logic        ready, mem_rd_req, mem_wr_req;
  logic [3:0]  hit_cnt, miss_cnt;

  int tests, fails;
  int unsigned exp_hits, exp_misses;

  // Reference model: cached line addresses, last-use stamps, SRAM contents.
  int unsigned lines[$];
  int unsigned stamp[int unsigned];
  int unsigned now_t;
  logic [31:0] sram_w[int unsigned];

  cache_ctrl_nway #(
    .ADDR_W(32), .DATA_W(32), .WAYS(2), .SETS(64), .LINE_WORDS(2), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .flush(flush), .mem_rd_req(mem_rd_req),
    .mem_wr_req(mem_wr_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sram_val(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'h3;
    if (sram_w.exists(w)) return sram_w[w];
    return {w[15:0] ^ 16'hC3A5, w[15:0]};
  endfunction

  function automatic int unsigned set_of(input int unsigned l);
    return (l >> 3) % 64;
  endfunction

  function automatic bit m_cached(input logic [31:0] a);
    int unsigned l;
    l = a & ~32'h7;
    foreach (lines[i]) if (lines[i] == l) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_use(input int unsigned l);
    now_t++;
    stamp[l] = now_t;
  endfunction

  function automatic void m_fill(input int unsigned l);
    int cnt;
    int vic;
    int unsigned best;
    cnt = 0; vic = -1; best = 32'hFFFF_FFFF;
    foreach (lines[i]) begin
      if (set_of(lines[i]) == set_of(l)) begin
        cnt++;
        if (stamp[lines[i]] < best) begin
          best = stamp[lines[i]];
          vic = i;
        end
      end
    end
    if (cnt >= NW) lines.delete(vic);
    lines.push_back(l);
    m_use(l);
  endfunction

  function automatic int unsigned sat(input int unsigned v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic do_read(input logic [31:0] a, input int lat, input bit fl_req, input bit fl_fill);
    bit hit;
    logic [31:0] line, exp_d;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_misses);
    rd_en = 1'b1; wr_en = 1'b0; addr = a; flush = fl_req;
    #1;
    hit = m_cached(a);
    line = a & ~32'h7;
    exp_d = sram_val(a);
    chk("rd_ready", ready, hit);
    if (hit) begin
      chk("hit_rdata", rdata, exp_d);
      m_use(line);
      exp_hits = sat(exp_hits);
      if (fl_req) lines.delete();
    end else begin
      if (fl_req) lines.delete();
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        flush = fl_fill && (k == 1);
        if (k == lat) begin
          mem_ready = 1'b1;
          mem_rdata = {sram_val(line + 32'd4), sram_val(line)};
        end
        #1;
        chk("rd_req", mem_rd_req, 64'd1);
        if (k == 1) chk("rd_addr", mem_addr, line);
        chk("miss_ready", ready, k == lat);
        if (k == lat) chk("miss_rdata", rdata, exp_d);
      end
      m_fill(line);
      exp_misses = sat(exp_misses);
      if (fl_fill) lines.delete();
    end
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int lat, input bit both);
    @(negedge clk);
    mem_ready = 1'b0;
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_misses);
    rd_en = both; wr_en = 1'b1; addr = a; wdata = d; flush = 1'b0;
    #1;
    chk("wr_ready0", ready, 64'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == lat) mem_ready = 1'b1;
      #1;
      chk("wr_req", mem_wr_req, 64'd1);
      if (k == 1) begin
        chk("wr_addr", mem_addr, a & ~32'h3);
        chk("wr_data", mem_wdata, d);
      end
      chk("wr_ready", ready, k == lat);
    end
    sram_w[a & ~32'h3] = d;
  endtask

  task automatic do_idle(input bit fl, input bit spur);
    @(negedge clk);
    mem_ready = spur;
    chk("hit_cnt", hit_cnt, exp_hits);
    chk("miss_cnt", miss_cnt, exp_misses);
    rd_en = 1'b0; wr_en = 1'b0; flush = fl;
    #1;
    chk("idle_ready", ready, 64'd1);
    chk("idle_rd_req", mem_rd_req, 64'd0);
    chk("idle_wr_req", mem_wr_req, 64'd0);
    if (fl) lines.delete();
  endtask

  initial begin
    logic [31:0] a;
    int op;
    tests = 0; fails = 0; exp_hits = 0; exp_misses = 0; now_t = 0;
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    addr = 32'd0; wdata = 32'd0; mem_rdata = 64'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", ready, 64'd1);
    chk("rst_rd_req", mem_rd_req, 64'd0);
    chk("rst_wr_req", mem_wr_req, 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_hit_cnt", hit_cnt, 64'd0);
    chk("rst_miss_cnt", miss_cnt, 64'd0);
    rst = 1'b1;

    // Cold miss then same-line hit
    do_read(32'h400, 4, 1'b0, 1'b0);
    do_read(32'h404, 4, 1'b0, 1'b0);

    // Reset in the middle of a fill
    @(negedge clk);
    mem_ready = 1'b0; rd_en = 1'b1; wr_en = 1'b0; addr = 32'h600; flush = 1'b0;
    #1;
    chk("mf_ready0", ready, 64'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("mf_req_on", mem_rd_req, 64'd1);
    rst = 1'b0; rd_en = 1'b0;
    #1;
    chk("mf_req_drop", mem_rd_req, 64'd0);
    chk("mf_ready", ready, 64'd1);
    chk("mf_hit_cnt", hit_cnt, 64'd0);
    chk("mf_miss_cnt", miss_cnt, 64'd0);
    lines.delete(); exp_hits = 0; exp_misses = 0;
    @(negedge clk);
    rst = 1'b1;
    do_idle(1'b0, 1'b1);

    // Conflict in set 0, write-through, write miss
    do_read(32'h400, 4, 1'b0, 1'b0);
    do_read(32'h600, 4, 1'b0, 1'b0);
    do_read(32'h400, 4, 1'b0, 1'b0);
    do_read(32'h800, 4, 1'b0, 1'b0);
    do_write(32'h404, 32'hDEADBEEF, 4, 1'b0);
    do_read(32'h404, 4, 1'b0, 1'b0);
    do_write(32'hA00, 32'h1234_5678, 4, 1'b1);
    do_read(32'hA00, 4, 1'b0, 1'b0);
    do_read(32'h600, 4, 1'b0, 1'b0);

    // Flush in idle, during a fill, and alongside a hit
    do_idle(1'b1, 1'b0);
    do_read(32'h400, 4, 1'b0, 1'b1);
    do_read(32'h400, 4, 1'b0, 1'b0);
    do_read(32'h404, 4, 1'b1, 1'b0);
    do_read(32'h404, 4, 1'b0, 1'b0);

    // Hit counter saturation
    for (int i = 0; i < 20; i++) do_read(32'h400, 4, 1'b0, 1'b0);
    do_idle(1'b0, 1'b0);
    chk("hit_sat", hit_cnt, 64'd15);

    // Random traffic over a few conflicting lines
    for (int i = 0; i < 300; i++) begin
      a = (32'($urandom_range(1, 4)) << 9) | (32'($urandom_range(0, 3)) << 3)
        | (32'($urandom_range(0, 1)) << 2);
      op = $urandom_range(0, 19);
      if (op < 12)       do_read(a, $urandom_range(1, 4), 1'b0, op == 0);
      else if (op < 17)  do_write(a, $urandom, $urandom_range(1, 4), op[0]);
      else if (op < 19)  do_idle(op == 18, 1'b0);
      else               do_read(a, $urandom_range(1, 4), 1'b1, 1'b0);
    end
    do_idle(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
